// File: rtl/pu_bus_sequencer_pkg.sv
// pu_bus_sequencer_pkg: program-word layout and FSM encoding shared by the sequencer files.
// Program word = {last, oe, wr, sel}; the flag offsets below are counted above the sel field.
package pu_bus_sequencer_pkg;
    localparam int PW_SEL   = 0;
    localparam int PW_WR    = 0;
    localparam int PW_OE    = 1;
    localparam int PW_LAST  = 2;
    localparam int PW_FLAGS = 3;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_e;
    function automatic int pw_width(int sel_w);
        return sel_w + PW_FLAGS;
    endfunction
endpackage

// File: rtl/seq_operand_fifo.sv
// seq_operand_fifo: 2-entry operand queue feeding the PU data/attr inputs.
// Ports: clk, rst (async active-low), push_i/pop_i strobes, data_i in,
//        head_o oldest entry, count_o occupancy (0..2). Caller guarantees no
//        push when full and no pop when empty; push+pop together keeps count.
module seq_operand_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    always_comb begin
        wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_i ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/pu_bus_sequencer.sv
// pu_bus_sequencer: microprogrammed bus initiator driving one PU's wr/oe/sel slave interface.
// Ports: clk, rst (async active-low); start/busy/done run control; op_valid/op_ready/
//        op_data/op_attr host operand push; signal_wr/oe/sel + pu_data_out/pu_attr_out
//        to the PU; pu_data_in/pu_attr_in from the PU; res_valid/res_data/res_attr result.
// The microprogram is an elaborated ROM image: word i sits at PROGRAM_INIT[i*PW_W +: PW_W].
module pu_bus_sequencer
    import pu_bus_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ATTR_WIDTH    = 4,
    parameter int SEL_WIDTH     = 4,
    parameter int PROGRAM_DEPTH = 16,
    parameter logic [PROGRAM_DEPTH*(SEL_WIDTH+3)-1:0] PROGRAM_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_data,
    input  logic [ATTR_WIDTH-1:0] op_attr,
    output logic                  signal_wr,
    output logic                  signal_oe,
    output logic [SEL_WIDTH-1:0]  signal_sel,
    output logic [DATA_WIDTH-1:0] pu_data_out,
    output logic [ATTR_WIDTH-1:0] pu_attr_out,
    input  logic [DATA_WIDTH-1:0] pu_data_in,
    input  logic [ATTR_WIDTH-1:0] pu_attr_in,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [ATTR_WIDTH-1:0] res_attr
);
    localparam int PW_W = pw_width(SEL_WIDTH);
    localparam int PC_W = $clog2(PROGRAM_DEPTH);
    localparam int QW   = DATA_WIDTH + ATTR_WIDTH;
    seq_state_e            state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PW_W-1:0]       word;
    logic                  w_wr, w_oe, w_last, issue, pop, push;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [1:0]            count;
    logic [QW-1:0]         head;
    logic                  wr_q, wr_d, oe_q, oe_d, res_valid_q, res_valid_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [QW-1:0]         pu_q, pu_d, res_q, res_d;
    assign word   = PROGRAM_INIT[pc_q*PW_W +: PW_W];
    assign w_sel  = word[PW_SEL +: SEL_WIDTH];
    assign w_wr   = word[SEL_WIDTH + PW_WR];
    assign w_oe   = word[SEL_WIDTH + PW_OE];
    assign w_last = word[SEL_WIDTH + PW_LAST];
    // A write step with no operand waiting stalls in place; the bus idles that cycle.
    assign issue    = (state_q == RUN) && !(w_wr && count == 2'd0);
    assign pop      = issue && w_wr;
    assign op_ready = count != 2'd2;
    assign push     = op_valid && op_ready;
    seq_operand_fifo #(.W(QW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({op_attr, op_data}),
        .head_o  (head),
        .count_o (count)
    );
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_d        = issue && w_wr;
        oe_d        = issue && w_oe;
        sel_d       = issue ? w_sel : '0;
        pu_d        = pop ? head : '0;
        res_valid_d = oe_q;
        res_d       = oe_q ? {pu_attr_in, pu_data_in} : res_q;
        case (state_q)
            IDLE: begin
                state_d = start ? RUN : IDLE;
                pc_d    = start ? '0 : pc_q;
            end
            RUN: begin
                pc_d    = issue ? pc_q + 1'b1 : pc_q;
                state_d = (issue && (w_last || pc_q == PC_W'(PROGRAM_DEPTH - 1))) ? DRAIN : RUN;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            wr_q        <= 1'b0;
            oe_q        <= 1'b0;
            sel_q       <= '0;
            pu_q        <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            sel_q       <= sel_d;
            pu_q        <= pu_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end
    assign busy        = state_q == RUN || state_q == DRAIN;
    assign done        = state_q == DONE;
    assign signal_wr   = wr_q;
    assign signal_oe   = oe_q;
    assign signal_sel  = sel_q;
    assign {pu_attr_out, pu_data_out} = pu_q;
    assign res_valid   = res_valid_q;
    assign {res_attr, res_data} = res_q;
endmodule
